// File: rtl/example_join_alu_pkg.sv
// Shared flag indices, result record and the wrap/saturate helper for the join ALU.
package example_pkg;
  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_BORROW = 1;
  localparam int MAX_W       = 64;

  typedef struct packed {
    logic             borrow;
    logic             carry;
    logic [MAX_W-1:0] dif;
    logic [MAX_W-1:0] sum;
  } as_res_t;

  // Operands arrive zero-extended to MAX_W; w is the live width (2..MAX_W).
  function automatic as_res_t add_sub_res(input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input int               w,
                                          input logic             sat);
    as_res_t          r;
    logic [MAX_W:0]   s;
    logic [MAX_W-1:0] mask;
    mask     = ~({MAX_W{1'b1}} << w);
    s        = {1'b0, a} + {1'b0, b};
    r.carry  = |(s >> w);
    r.sum    = s[MAX_W-1:0] & mask;
    r.borrow = a < b;
    r.dif    = (a - b) & mask;
    if (sat) begin
      if (r.carry)  r.sum = mask;
      if (r.borrow) r.dif = '0;
    end
    return r;
  endfunction
endpackage

// File: rtl/example_join_alu_join_fifo.sv
// Operand FIFO: no full pass-through, no empty bypass; head is the oldest entry.
module join_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic [AW:0]                 cnt;
  logic                        do_push, do_pop;

  assign push_ready = !rst && (cnt != FULL_CNT);
  assign head_valid = cnt != '0;
  assign head       = mem[rptr];
  assign do_push    = push & push_ready;
  assign do_pop     = pop & head_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // do_push already excludes reset through push_ready.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/example_join_alu.sv
// Joins independent A/B operand streams pairwise and emits registered sum/difference.
module example_join_alu
  import example_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [1:0]       o_flags,
  output logic [CNT_W-1:0] pair_count
);
  // Lane 0 carries operand A, lane 1 operand B.
  logic [1:0]            in_vld, in_rdy, hv;
  logic [1:0][WIDTH-1:0] in_dat, hd;
  logic                  fire;
  as_res_t               res;
  logic                  unused_res;

  assign in_vld  = {b_valid, a_valid};
  assign in_dat  = {b, a};
  assign a_ready = in_rdy[0];
  assign b_ready = in_rdy[1];
  assign fire    = (&hv) & (!o_valid | o_ready);

  generate
    for (genvar i = 0; i < 2; i++) begin : g_lane
      join_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (in_vld[i]),
        .push_data  (in_dat[i]),
        .push_ready (in_rdy[i]),
        .pop        (fire),
        .head_valid (hv[i]),
        .head       (hd[i])
      );
    end
  endgenerate

  assign res        = add_sub_res(MAX_W'(hd[0]), MAX_W'(hd[1]), WIDTH, sat_en);
  assign unused_res = ^{res.sum >> WIDTH, res.dif >> WIDTH};

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o1         <= '0;
      o2         <= '0;
      o_flags    <= '0;
      pair_count <= '0;
    end else begin
      if (fire) begin
        o_valid              <= 1'b1;
        o1                   <= res.sum[WIDTH-1:0];
        o2                   <= res.dif[WIDTH-1:0];
        o_flags[FLAG_BORROW] <= res.borrow;
        o_flags[FLAG_CARRY]  <= res.carry;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
      if (o_valid && o_ready) pair_count <= pair_count + CNT_W'(1);
    end
  end
endmodule
